pipe_stage_elastic: RTL and testbench
=====================================

# pipe_stage_elastic

Parametrised elastic pipeline stage register for the pipelined datapath: a WIDTH-bit latch between two pipeline stages with valid/ready handshaking, a one-entry skid buffer, a global stall enable and a synchronous flush. It generalises the fixed per-field stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) into one reusable block. Downstream back-pressure no longer has to be broadcast combinationally to every upstream stage in the same cycle. Control fields and data fields are packed by the instantiating stage into `in_data`.

## Interface
- WIDTH, 128, bits in the packed stage payload (control + data); WIDTH ≥ 1
- ZERO_ON_FLUSH, 1, 1: flush clears the main and skid data registers to 0; 0: flush clears only valid state and leaves data unchanged
- CLK  input  1  clock; all state updates on the rising edge
- nRST  input  1  reset, asynchronous, active-low
- en  input  1  global advance enable (cache-hit qualifier); 0 freezes all transfers
- flush  input  1  synchronous squash of stage contents; independent of `en`
- in_valid  input  1  upstream presents `in_data`
- in_ready  output  1  stage accepts `in_data` this cycle
- in_data  input  WIDTH  upstream payload
- out_valid  output  1  `out_data` holds a valid entry
- out_ready  input  1  downstream accepts `out_data` this cycle
- out_data  output  WIDTH  payload presented downstream
- occupancy  output  2  number of entries held (0, 1 or 2)

## Operation
- Storage: main register `M` drives `out_data`; skid register `S` holds an entry only when the stage is full.
- States: EMPTY (occupancy 0), ONE (M valid), FULL (M and S valid). Encoding is free; `occupancy` reflects the state.
- Combinational handshake terms:
  - in_ready = (state != FULL) & en & !flush
  - in_fire = in_valid & in_ready
  - out_fire = out_valid & out_ready & en & !flush
- out_valid = (state != EMPTY). It is a registered state term and does not depend on `en` or `flush`. The consumer qualifies with `en` itself.
- Transitions when flush = 0:
  - EMPTY: in_fire → ONE, M ← in_data.
  - ONE: in_fire & out_fire → ONE, M ← in_data.
  - ONE: in_fire only → FULL, S ← in_data.
  - ONE: out_fire only → EMPTY.
  - FULL: out_fire → ONE, M ← S. No in_fire is possible in FULL.
  - No fire: hold state and data.
- flush = 1, any state: next state EMPTY. If ZERO_ON_FLUSH = 1, M and S ← 0. `in_data` in that cycle is dropped and never accepted. Flush takes priority over `en` and over every handshake.
- Order is strictly FIFO. Every accepted entry is presented exactly once, and no entry is duplicated or reordered.
- en = 0 with flush = 0: no fires, state and data frozen.

## Timing
- Reset, asynchronous, while nRST = 0: state EMPTY, M = 0, S = 0.
- Resulting output values during reset: out_valid = 0, occupancy = 0, out_data = 0. in_ready = 0 because en and flush are don't-care only after release; it is 1 on the first cycle after release when en = 1 and flush = 0.
- Reset asserted mid-operation discards both entries immediately, with no clock needed.
- Latency: an entry accepted at edge k is visible on `out_valid`/`out_data` after edge k (one cycle).
- Throughput: one transfer per cycle sustained while out_ready = 1 and en = 1.
- in_ready has a combinational path from `en` and `flush` only. It has no combinational path from `out_ready`; this is the purpose of the skid entry.
- out_data and out_valid come straight from registers, with no combinational path from any input.
- Boundary cases:
  - FULL with out_ready = 0: in_ready = 0, contents held indefinitely.
  - Simultaneous in_fire and out_fire in ONE: the old M leaves, the new entry lands in M, occupancy stays 1.
  - Flush while FULL: both entries are lost and occupancy reaches 0 in one cycle.

## Test plan
- Reset: assert nRST = 0 mid-stream with two entries held → out_valid = 0, occupancy = 0, out_data = 0 immediately. After release with en = 1 → in_ready = 1.
- Streaming: en = 1, out_ready = 1, in_valid = 1 with payloads 0x1, 0x2, 0x3 on consecutive cycles → out_data shows 0x1, 0x2, 0x3 on the next three cycles, occupancy stays 1, in_ready stays 1.
- Back-pressure skid: feed 0xA then 0xB with out_ready = 0 → occupancy 2, in_ready = 0. Raise out_ready → 0xA then 0xB delivered in order, in_ready returns to 1 after the first pop.
- Stall: while occupancy = 1 holding 0x55, drive en = 0 for 3 cycles with in_valid = 1 and out_ready = 1 → no transfers, in_ready = 0, out_data = 0x55. With en = 1 again, flow resumes.
- Flush priority: occupancy 2, flush = 1 with in_valid = 1 (payload 0x77) and en = 0 → next cycle occupancy 0, out_valid = 0, out_data = 0 (ZERO_ON_FLUSH = 1), and 0x77 never appears.
- Parameters: WIDTH = 1 and ZERO_ON_FLUSH = 0, flush while holding 1 → out_valid = 0 and out_data remains 1. Random valid/ready/en/flush for 10k cycles, checked against a scoreboard → no loss (except flushed entries), duplication or reordering.

Source files
------------

// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic: valid/ready pipeline register with one-entry skid buffer, stall enable and flush
module pipe_stage_elastic #(
  parameter int WIDTH         = 128,
  parameter bit ZERO_ON_FLUSH = 1'b1
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             en,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
  state_t           r_state;
  logic [WIDTH-1:0] r_m;
  logic [WIDTH-1:0] r_s;
  logic             w_in_fire;
  logic             w_out_fire;
  // in_ready depends only on state, en and flush, so back-pressure never ripples upstream combinationally
  assign in_ready   = nRST & (r_state != FULL) & en & !flush;
  assign w_in_fire  = in_valid & in_ready;
  assign out_valid  = (r_state != EMPTY);
  assign w_out_fire = out_valid & out_ready & en & !flush;
  assign out_data   = r_m;
  assign occupancy  = r_state;
  // state and storage update; flush overrides every handshake, FULL drains the skid entry into M
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= EMPTY;
      r_m     <= '0;
      r_s     <= '0;
    end else if (flush) begin
      r_state <= EMPTY;
      if (ZERO_ON_FLUSH) begin
        r_m <= '0;
        r_s <= '0;
      end
    end else begin
      case (r_state)
        EMPTY: if (w_in_fire) begin
          r_state <= ONE;
          r_m     <= in_data;
        end
        ONE: if (w_in_fire && w_out_fire) r_m <= in_data;
          else if (w_in_fire) begin
            r_state <= FULL;
            r_s     <= in_data;
          end else if (w_out_fire) r_state <= EMPTY;
        FULL: if (w_out_fire) begin
          r_state <= ONE;
          r_m     <= r_s;
        end
        default: r_state <= EMPTY;
      endcase
    end
  end
endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb_pipe_stage_elastic: directed and random checks of the elastic stage against a FIFO scoreboard
module tb_pipe_stage_elastic;
  logic         CLK = 1'b0;
  logic         nRST = 1'b0;
  logic         en = 1'b1;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_data;
  logic [1:0]   occupancy;
  logic         s_en = 1'b1;
  logic         s_flush = 1'b0;
  logic         s_in_valid = 1'b0;
  logic         s_in_ready;
  logic [0:0]   s_in_data = 1'b0;
  logic         s_out_valid;
  logic         s_out_ready = 1'b0;
  logic [0:0]   s_out_data;
  logic [1:0]   s_occupancy;
  logic [127:0] q[$];
  int           mon_sz = 0;
  int           total = 0;
  int           bad = 0;

  pipe_stage_elastic #(.WIDTH(128), .ZERO_ON_FLUSH(1'b1)) dut (
    .CLK(CLK), .nRST(nRST), .en(en), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
  );

  pipe_stage_elastic #(.WIDTH(1), .ZERO_ON_FLUSH(1'b0)) dut_small (
    .CLK(CLK), .nRST(nRST), .en(s_en), .flush(s_flush),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
    .occupancy(s_occupancy)
  );

  initial forever #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input logic v, input logic [127:0] d, input logic r, input logic e, input logic f);
    @(posedge CLK);
    #1;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    en        = e;
    flush     = f;
    @(negedge CLK);
  endtask

  // monitor: checks presented state against the scoreboard and pops on every downstream transfer
  always @(negedge CLK) begin
    if (nRST) begin
      int sz;
      sz = q.size();
      chk("mon_valid", out_valid, sz != 0);
      chk("mon_occ", occupancy, sz);
      chk("mon_in_ready", in_ready, (sz < 2) && en && !flush);
      mon_sz = sz;
      if (sz != 0 && out_ready && en && !flush) begin
        chk("mon_data", out_data, q[0]);
        void'(q.pop_front());
      end
    end
  end

  // feeder: records every accepted input as an expected output, flush discards all pending entries
  always @(negedge CLK) begin
    if (nRST) begin
      #1;
      if (flush) q.delete();
      else if (in_valid && en && mon_sz < 2) q.push_back(in_data);
    end
  end

  initial begin
    #12;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_occ", occupancy, 2'd0);
    chk("rst_data", out_data, 128'h0);
    chk("rst_in_ready", in_ready, 1'b0);
    #4 nRST = 1'b1;
    #1 chk("rel_in_ready", in_ready, 1'b1);
    step(1, 128'h1, 1, 1, 0);
    chk("st_occ0", occupancy, 2'd0);
    step(1, 128'h2, 1, 1, 0);
    chk("st_d1", out_data, 128'h1);
    chk("st_occ1", occupancy, 2'd1);
    chk("st_ir1", in_ready, 1'b1);
    step(1, 128'h3, 1, 1, 0);
    chk("st_d2", out_data, 128'h2);
    chk("st_occ2", occupancy, 2'd1);
    step(0, 128'h0, 1, 1, 0);
    chk("st_d3", out_data, 128'h3);
    chk("st_ir3", in_ready, 1'b1);
    step(0, 128'h0, 1, 1, 0);
    chk("st_empty", occupancy, 2'd0);
    step(1, 128'hA, 0, 1, 0);
    step(1, 128'hB, 0, 1, 0);
    chk("bp_a", out_data, 128'hA);
    step(0, 128'h0, 0, 1, 0);
    chk("bp_occ2", occupancy, 2'd2);
    chk("bp_ir0", in_ready, 1'b0);
    chk("bp_hold", out_data, 128'hA);
    step(0, 128'h0, 1, 1, 0);
    chk("bp_still_a", out_data, 128'hA);
    step(0, 128'h0, 1, 1, 0);
    chk("bp_b", out_data, 128'hB);
    chk("bp_occ1", occupancy, 2'd1);
    chk("bp_ir1", in_ready, 1'b1);
    step(0, 128'h0, 1, 1, 0);
    chk("bp_empty", occupancy, 2'd0);
    step(1, 128'h55, 0, 1, 0);
    step(0, 128'h0, 0, 1, 0);
    chk("stl_load", out_data, 128'h55);
    for (int i = 0; i < 3; i++) begin
      step(1, 128'h66, 1, 0, 0);
      chk("stl_ir", in_ready, 1'b0);
      chk("stl_data", out_data, 128'h55);
      chk("stl_occ", occupancy, 2'd1);
    end
    step(1, 128'h66, 1, 1, 0);
    chk("stl_ir_back", in_ready, 1'b1);
    step(0, 128'h0, 1, 1, 0);
    chk("stl_resume", out_data, 128'h66);
    step(0, 128'h0, 1, 1, 0);
    step(1, 128'h88, 0, 1, 0);
    step(1, 128'h99, 0, 1, 0);
    step(0, 128'h0, 0, 1, 0);
    chk("fl_occ2", occupancy, 2'd2);
    step(1, 128'h77, 0, 0, 1);
    chk("fl_ir", in_ready, 1'b0);
    step(0, 128'h0, 0, 1, 0);
    chk("fl_occ", occupancy, 2'd0);
    chk("fl_valid", out_valid, 1'b0);
    chk("fl_zero", out_data, 128'h0);
    step(0, 128'h0, 1, 1, 0);
    chk("fl_no77", out_valid, 1'b0);
    step(1, 128'hC1, 0, 1, 0);
    step(1, 128'hC2, 0, 1, 0);
    step(0, 128'h0, 0, 1, 0);
    chk("mr_occ2", occupancy, 2'd2);
    #2 nRST = 1'b0;
    q.delete();
    #1;
    chk("mr_valid", out_valid, 1'b0);
    chk("mr_occ", occupancy, 2'd0);
    chk("mr_data", out_data, 128'h0);
    @(negedge CLK);
    #2 nRST = 1'b1;
    #1 chk("mr_ir", in_ready, 1'b1);
    for (int i = 0; i < 10000; i++)
      step(1'($urandom % 2), {$urandom, $urandom, $urandom, $urandom}, 1'($urandom % 2),
           ($urandom % 5) != 0, ($urandom % 20) == 0);
    step(0, 128'h0, 1, 1, 0);
    step(0, 128'h0, 1, 1, 0);
    step(0, 128'h0, 1, 1, 0);
    chk("rnd_drain", occupancy, 2'd0);
    @(posedge CLK);
    #1 s_in_valid = 1'b1;
    s_in_data = 1'b1;
    @(posedge CLK);
    #1 s_in_valid = 1'b0;
    @(negedge CLK);
    chk("sm_valid", s_out_valid, 1'b1);
    chk("sm_data", s_out_data, 1'b1);
    @(posedge CLK);
    #1 s_flush = 1'b1;
    @(posedge CLK);
    #1 s_flush = 1'b0;
    @(negedge CLK);
    chk("sm_fl_valid", s_out_valid, 1'b0);
    chk("sm_fl_occ", s_occupancy, 2'd0);
    chk("sm_fl_data", s_out_data, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
